// File: rtl/txll_frame_ctrl.sv
// ---------------------------------------------------------------------------
// txll_frame_ctrl
//   Pulls complete frames out of a first-word-fall-through FIFO and hands
//   them dword by dword to the transport/link layer. A frame is opened only
//   once the FIFO holds a whole frame, the link is asked for a grant, and the
//   frame is streamed with zero-latency pops (the FIFO head is presented
//   directly as tx_data). Frames longer than C_MAX_DWORDS are cut short,
//   with the remainder discarded, and a frame that never gets a grant is
//   flushed from the FIFO.
//
// Ports
//   rd_clk        clock; all logic runs in this domain
//   rst           synchronous, active-high reset
//   fifo_do       FIFO head: [31:0] data, [34] EOF marker, other bits unused
//   fifo_empty    FIFO head is not valid
//   fifo_eof_rdy  at least one complete frame is resident in the FIFO
//   fifo_rd_en    pop the FIFO head
//   tx_req        request the link to open a frame
//   tx_gnt        link accepts the request (one-cycle pulse)
//   tx_data       frame dword
//   tx_valid      tx_data is valid
//   tx_ready      link accepts the dword (low = HOLD)
//   tx_sof        first dword of the frame, qualified by tx_valid
//   tx_eof        last dword of the frame, qualified by tx_valid
//   tx_done       link finished its end-of-frame handshake (pulse)
//   tx_ok         status alongside tx_done: 1 = R_OK, 0 = R_ERR
//   frame_len     dwords accepted by the link in the last/current frame
//   sts_done      one-cycle pulse when a frame is finished
//   sts_err       latched status: 00 ok, 01 R_ERR, 10 grant timeout,
//                 11 overlength
//   busy          controller is not idle
// ---------------------------------------------------------------------------
module txll_frame_ctrl #(
  parameter int unsigned C_MAX_DWORDS  = 2049,
  parameter int unsigned C_GNT_TIMEOUT = 1023
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic [35:0] fifo_do,
  input  logic        fifo_empty,
  input  logic        fifo_eof_rdy,
  output logic        fifo_rd_en,
  output logic        tx_req,
  input  logic        tx_gnt,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  input  logic        tx_done,
  input  logic        tx_ok,
  output logic [11:0] frame_len,
  output logic        sts_done,
  output logic [1:0]  sts_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_XFER      = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_FLUSH     = 3'd5;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RERR    = 2'b01;
  localparam logic [1:0] ERR_GNT_TO  = 2'b10;
  localparam logic [1:0] ERR_OVERLEN = 2'b11;

  localparam int unsigned GW = (C_GNT_TIMEOUT < 1) ? 1 : $clog2(C_GNT_TIMEOUT + 1);
  localparam int unsigned DW = (C_MAX_DWORDS < 2) ? 1 : $clog2(C_MAX_DWORDS + 1);

  localparam logic [GW-1:0] GNT_LIMIT = GW'(C_GNT_TIMEOUT);
  localparam logic [DW-1:0] LAST_SLOT = DW'(C_MAX_DWORDS - 1);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [GW-1:0] gnt_cnt;
  // Frame position counter kept apart from frame_len: frame_len saturates at
  // 12 bits, while the overlength cut must work for any C_MAX_DWORDS.
  logic [DW-1:0] dw_cnt;
  logic          sof_pend;

  logic          head_eof;
  logic          at_last_slot;
  logic          accept;
  logic          unused_bits;

  assign head_eof    = fifo_do[34];
  assign unused_bits = ^{fifo_do[35], fifo_do[33:32]};

  // -------------------------------------------------------------------------
  // Link/FIFO side outputs are pure functions of state and the FIFO head so
  // a pop happens in the same cycle the link accepts the dword.
  // -------------------------------------------------------------------------
  always_comb begin
    tx_req       = (state == S_REQ);
    busy         = (state != S_IDLE);
    tx_valid     = (state == S_XFER) && !fifo_empty;
    tx_data      = (state == S_XFER) ? fifo_do[31:0] : '0;
    at_last_slot = (dw_cnt == LAST_SLOT);
    tx_sof       = tx_valid && sof_pend;
    // The dword that fills the last slot closes the frame on the link even
    // when the FIFO word carries no EOF marker.
    tx_eof       = tx_valid && (head_eof || at_last_slot);
    accept       = tx_valid && tx_ready;

    case (state)
      S_XFER:           fifo_rd_en = accept;
      S_DRAIN, S_FLUSH: fifo_rd_en = !fifo_empty;
      default:          fifo_rd_en = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (fifo_eof_rdy) state_nx = S_REQ;
      end
      S_REQ: begin
        // A grant arriving on the timeout cycle still wins.
        if (tx_gnt)                    state_nx = S_XFER;
        else if (gnt_cnt == GNT_LIMIT) state_nx = S_FLUSH;
      end
      S_XFER: begin
        if (accept && tx_eof) state_nx = head_eof ? S_WAIT_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_rd_en && head_eof) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) state_nx = S_IDLE;
      end
      S_FLUSH: begin
        if (fifo_rd_en && head_eof) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters and status
  // -------------------------------------------------------------------------
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt_cnt   <= '0;
      dw_cnt    <= '0;
      sof_pend  <= 1'b0;
      frame_len <= '0;
      sts_done  <= 1'b0;
      sts_err   <= ERR_OK;
    end else begin
      state    <= state_nx;
      sts_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fifo_eof_rdy) begin
            sts_err <= ERR_OK;
            gnt_cnt <= '0;
          end
        end

        S_REQ: begin
          if (tx_gnt) begin
            frame_len <= '0;
            dw_cnt    <= '0;
            sof_pend  <= 1'b1;
          end else if (gnt_cnt == GNT_LIMIT) begin
            sts_err <= ERR_GNT_TO;
          end else begin
            gnt_cnt <= gnt_cnt + 1'b1;
          end
        end

        S_XFER: begin
          if (accept) begin
            sof_pend <= 1'b0;
            dw_cnt   <= dw_cnt + 1'b1;
            if (frame_len != '1) frame_len <= frame_len + 1'b1;
            if (at_last_slot && !head_eof) sts_err <= ERR_OVERLEN;
          end
        end

        S_WAIT_DONE: begin
          if (tx_done) begin
            sts_done <= 1'b1;
            // An overlength cut is the more useful diagnosis; R_ERR does not
            // overwrite it.
            if (!tx_ok && (sts_err != ERR_OVERLEN)) sts_err <= ERR_RERR;
          end
        end

        S_FLUSH: begin
          if (fifo_rd_en && head_eof) sts_done <= 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_txll_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_txll_frame_ctrl
//   Bench for txll_frame_ctrl. The bench plays both the FWFT FIFO (a queue of
//   36-bit words) and the link layer. Each frame is generated up front, and
//   the expected dword stream, pop count, frame length and status are derived
//   from the frame contents and the scenario, then compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_txll_frame_ctrl;

  localparam int MAXD = 2049;
  localparam int GTO  = 1023;

  logic        rd_clk = 1'b0;
  logic        rst;
  logic [35:0] fifo_do;
  logic        fifo_empty;
  logic        fifo_eof_rdy;
  logic        fifo_rd_en;
  logic        tx_req;
  logic        tx_gnt;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sof;
  logic        tx_eof;
  logic        tx_done;
  logic        tx_ok;
  logic [11:0] frame_len;
  logic        sts_done;
  logic [1:0]  sts_err;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] fifo_q[$];
  int          eof_cnt = 0;
  int          pops = 0;
  logic        rst_next = 1'b1;
  logic [1:0]  last_err = 2'b00;

  txll_frame_ctrl #(
    .C_MAX_DWORDS (MAXD),
    .C_GNT_TIMEOUT(GTO)
  ) dut (
    .rd_clk      (rd_clk),
    .rst         (rst),
    .fifo_do     (fifo_do),
    .fifo_empty  (fifo_empty),
    .fifo_eof_rdy(fifo_eof_rdy),
    .fifo_rd_en  (fifo_rd_en),
    .tx_req      (tx_req),
    .tx_gnt      (tx_gnt),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .tx_done     (tx_done),
    .tx_ok       (tx_ok),
    .frame_len   (frame_len),
    .sts_done    (sts_done),
    .sts_err     (sts_err),
    .busy        (busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change only on the falling edge; outputs are sampled 1 time unit
  // later, well away from the rising edge.
  task automatic drive_inputs(input bit gap, input bit gnt, input bit rdy, input bit dn, input bit ok);
    @(negedge rd_clk);
    rst          = rst_next;
    tx_gnt       = gnt;
    tx_ready     = rdy;
    tx_done      = dn;
    tx_ok        = ok;
    fifo_eof_rdy = (eof_cnt != 0);
    if (gap || fifo_q.size() == 0) begin
      fifo_empty = 1'b1;
      fifo_do    = 36'({$urandom(), $urandom()});
    end else begin
      fifo_empty = 1'b0;
      fifo_do    = fifo_q[0];
    end
    #1;
  endtask

  task automatic step_edge();
    logic        take;
    logic [35:0] x;
    take = fifo_rd_en && !fifo_empty;
    check_val("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
    @(posedge rd_clk);
    if (take) begin
      x = fifo_q.pop_front();
      if (x[34]) eof_cnt--;
      pops++;
    end
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_val("idle_busy", busy, 0);
      check_val("idle_req", tx_req, 0);
      check_val("idle_rd_en", fifo_rd_en, 0);
      check_val("idle_err_held", sts_err, last_err);
      step_edge();
    end
  endtask

  // gnt_dly < 0: never grant. mode 0: ready, no gaps; 1: HOLD 4 cycles on
  // the second dword; 2: FIFO empty 5 cycles before the second dword;
  // 3: random HOLD/gaps/noise. abort_at > 0: reset after that many dwords.
  task automatic run_frame(input int len, input int gnt_dly, input int mode,
                           input bit ok, input bit done_at_eof, input int abort_at);
    logic [35:0] w[$];
    logic [35:0] x;
    int          exp_acc, idx, k, guard, hold, gapc, waitc;
    logic [1:0]  exp_err;
    bit          gap, rdy, gnt, dn;

    exp_acc = (len > MAXD) ? MAXD : len;
    exp_err = (len > MAXD) ? 2'b11 : (ok ? 2'b00 : 2'b01);
    pops    = 0;
    for (int i = 0; i < len; i++) begin
      x     = 36'({$urandom(), $urandom()});
      x[34] = (i == len - 1);
      w.push_back(x);
      fifo_q.push_back(x);
      if (x[34]) eof_cnt++;
    end

    k = 0;
    drive_inputs(0, 0, 1, 0, 1);
    while (!tx_req && k < 4) begin
      check_val("pre_req_rd_en", fifo_rd_en, 0);
      step_edge();
      k++;
      drive_inputs(0, 0, 1, 0, 1);
    end
    check_val("req_latency", k, 1);

    if (gnt_dly < 0) begin
      k = 0;
      while (tx_req && k < GTO + 10) begin
        check_val("req_valid", tx_valid, 0);
        check_val("req_rd_en", fifo_rd_en, 0);
        if (k == 0) check_val("req_err_clr", sts_err, 0);
        step_edge();
        k++;
        drive_inputs(0, 0, 1, 0, 1);
      end
      check_val("gnt_timeout_window", (k >= GTO && k <= GTO + 1), 1);
      guard = 0;
      while (pops < len && guard < 4 * len + 20) begin
        check_val("flush_valid", tx_valid, 0);
        check_val("flush_req", tx_req, 0);
        check_val("flush_rd_en", fifo_rd_en, !fifo_empty);
        check_val("flush_busy", busy, 1);
        step_edge();
        guard++;
        drive_inputs($urandom_range(0, 3) == 0, 0, 1, 0, 1);
      end
      check_val("flush_pops", pops, len);
      check_val("flush_sts_done", sts_done, 1);
      check_val("flush_busy_end", busy, 0);
      check_val("flush_sts_err", sts_err, 2'b10);
      step_edge();
      drive_inputs(0, 0, 1, 0, 1);
      check_val("flush_done_pulse", sts_done, 0);
      step_edge();
      last_err = 2'b10;
      return;
    end

    k = 0;
    while (k < gnt_dly) begin
      check_val("req_asserted", tx_req, 1);
      check_val("req_valid", tx_valid, 0);
      check_val("req_err_clr", sts_err, 0);
      step_edge();
      k++;
      drive_inputs(0, k == gnt_dly, 1, 0, 1);
    end
    check_val("req_at_gnt", tx_req, 1);
    step_edge();

    idx = 0; hold = 0; gapc = 0; guard = 0;
    while (idx < exp_acc && guard < 8 * len + 50) begin
      if (abort_at != 0 && idx == abort_at) break;
      gap = 0; rdy = 1; gnt = 0; dn = 0;
      case (mode)
        1: if (idx == 1 && hold < 4) begin rdy = 0; hold++; end
        2: if (idx == 1 && gapc < 5) begin gap = 1; gapc++; end
        3: begin
          gap = ($urandom_range(0, 3) == 0);
          rdy = ($urandom_range(0, 2) != 0);
          gnt = 1'($urandom_range(0, 1));
          dn  = ($urandom_range(0, 7) == 0);
        end
        default: ;
      endcase
      if (done_at_eof && idx == exp_acc - 1 && !gap && rdy) dn = 1;
      drive_inputs(gap, gnt, rdy, dn, ok);
      check_val("xfer_valid", tx_valid, !gap);
      check_val("xfer_len", frame_len, idx);
      if (!gap) begin
        check_val("xfer_data", tx_data, w[idx][31:0]);
        check_val("xfer_sof", tx_sof, idx == 0);
        check_val("xfer_eof", tx_eof, idx == exp_acc - 1);
        check_val("xfer_rd_en", fifo_rd_en, rdy);
      end else begin
        check_val("gap_rd_en", fifo_rd_en, 0);
      end
      step_edge();
      guard++;
      if (!gap && rdy) idx++;
    end

    if (abort_at != 0) begin
      rst_next = 1'b1;
      drive_inputs(0, 0, 0, 0, 1);
      step_edge();
      fifo_q.delete();
      eof_cnt  = 0;
      rst_next = 1'b0;
      drive_inputs(0, 0, 1, 0, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_valid", tx_valid, 0);
      check_val("rst_frame_len", frame_len, 0);
      check_val("rst_sts_err", sts_err, 0);
      check_val("rst_req", tx_req, 0);
      step_edge();
      last_err = 2'b00;
      return;
    end

    check_val("xfer_pops", pops, exp_acc);
    drive_inputs(0, 0, 1, 0, 1);
    if (len > MAXD) begin
      guard = 0;
      while (pops < len && guard < 4 * len + 20) begin
        check_val("drain_valid", tx_valid, 0);
        check_val("drain_rd_en", fifo_rd_en, !fifo_empty);
        step_edge();
        guard++;
        drive_inputs($urandom_range(0, 2) == 0, 0, 1, 0, 1);
      end
      check_val("drain_pops", pops, len);
    end

    waitc = $urandom_range(0, 3);
    for (int i = 0; i <= waitc; i++) begin
      check_val("wait_busy", busy, 1);
      check_val("wait_no_done", sts_done, 0);
      check_val("wait_valid", tx_valid, 0);
      step_edge();
      drive_inputs(0, 1'($urandom_range(0, 1)), 1, i == waitc, ok);
    end
    check_val("done_cycle_busy", busy, 1);
    step_edge();
    drive_inputs(0, 0, 1, 0, 1);
    check_val("sts_done_pulse", sts_done, 1);
    check_val("end_busy", busy, 0);
    check_val("end_sts_err", sts_err, exp_err);
    check_val("end_frame_len", frame_len, exp_acc);
    step_edge();
    drive_inputs(0, 0, 1, 0, 1);
    check_val("sts_done_single", sts_done, 0);
    step_edge();
    last_err = exp_err;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before 900000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tx_gnt = 1'b0; tx_ready = 1'b0; tx_done = 1'b0; tx_ok = 1'b0;
    fifo_do = '0; fifo_empty = 1'b1; fifo_eof_rdy = 1'b0;

    rst_next = 1'b1;
    drive_inputs(0, 0, 0, 0, 0);
    step_edge();
    drive_inputs(0, 0, 0, 0, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_req", tx_req, 0);
    check_val("reset_valid", tx_valid, 0);
    check_val("reset_rd_en", fifo_rd_en, 0);
    check_val("reset_sof_eof", {tx_sof, tx_eof}, 0);
    check_val("reset_data", tx_data, 0);
    check_val("reset_frame_len", frame_len, 0);
    check_val("reset_sts", {sts_done, sts_err}, 0);
    step_edge();
    rst_next = 1'b0;
    idle_noise(3);

    run_frame(3, 2, 0, 1, 0, 0);      idle_noise(2);
    run_frame(3, 2, 1, 1, 0, 0);      idle_noise(2);
    run_frame(3, 2, 2, 1, 0, 0);      idle_noise(2);
    run_frame(3, 1, 0, 0, 1, 0);      idle_noise(3);
    run_frame(4, -1, 0, 1, 0, 0);     idle_noise(3);
    run_frame(2060, 1, 0, 1, 0, 0);   idle_noise(2);
    run_frame(5, 1, 0, 1, 0, 2);      idle_noise(2);
    run_frame(1, 1, 0, 1, 1, 0);      idle_noise(2);
    run_frame(MAXD, 3, 3, 1, 1, 0);   idle_noise(2);
    run_frame(MAXD + 5, 1, 3, 0, 1, 0); idle_noise(2);
    for (int i = 0; i < 12; i++) begin
      run_frame($urandom_range(1, 40), $urandom_range(1, 5), 3,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      idle_noise($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/txll_frame_ctrl.md
TXLL_FRAME_CTRL -- requirements
Module: txll_frame_ctrl

Interface
REQ-001 SHALL have parameter C_MAX_DWORDS, default 2049, max dwords per frame (1 header + 2048 data).
REQ-002 SHALL have parameter C_GNT_TIMEOUT, default 1023, rd_clk cycles to wait for tx_gnt before abort.
REQ-003 rd_clk  input  1  clock; all logic in this domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_do  input  36  FWFT FIFO head word; [31:0] data, [34] EOF marker, [35],[33],[32] ignored.
REQ-006 fifo_empty  input  1  FIFO head invalid.
REQ-007 fifo_eof_rdy  input  1  at least one complete frame resident in FIFO.
REQ-008 fifo_rd_en  output  1  pop FIFO head.
REQ-009 tx_req  output  1  request link layer to open a frame.
REQ-010 tx_gnt  input  1  link layer accepts request (single-cycle pulse).
REQ-011 tx_data  output  32  frame dword.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  link accepts dword (low = HOLD).
REQ-014 tx_sof  output  1  first dword of frame, qualified by tx_valid.
REQ-015 tx_eof  output  1  last dword of frame, qualified by tx_valid.
REQ-016 tx_done  input  1  link reports end-of-frame handshake complete (pulse).
REQ-017 tx_ok  input  1  status with tx_done: 1 = R_OK, 0 = R_ERR.
REQ-018 frame_len  output  12  dwords sent in last/current frame.
REQ-019 sts_done  output  1  one-cycle pulse, frame finished.
REQ-020 sts_err  output  2  latched status: 00 ok, 01 R_ERR, 10 grant timeout, 11 overlength.
REQ-021 busy  output  1  high in any state except IDLE.

Function
REQ-022 SHALL implement states IDLE, REQ, XFER, DRAIN, WAIT_DONE, FLUSH.
REQ-023 IDLE->REQ when fifo_eof_rdy=1; tx_req=1 only in REQ.
REQ-024 REQ->XFER on tx_gnt=1; REQ->FLUSH with sts_err=10 when grant counter reaches C_GNT_TIMEOUT.
REQ-025 In XFER, tx_valid = !fifo_empty; tx_data = fifo_do[31:0]; fifo_rd_en = tx_valid & tx_ready (zero-latency, combinational).
REQ-026 tx_sof SHALL be 1 on the first tx_valid dword after entering XFER until that dword is accepted.
REQ-027 tx_eof = tx_valid & fifo_do[34]; accepted EOF dword moves XFER->WAIT_DONE.
REQ-028 fifo_empty mid-frame SHALL deassert tx_valid (underrun wait), no error, no state change.
REQ-029 frame_len SHALL clear on REQ->XFER and increment by 1 per accepted dword, saturating at 4095.
REQ-030 Accepting dword number C_MAX_DWORDS without EOF SHALL force tx_eof=1 on that dword, set sts_err=11, go to DRAIN.
REQ-031 DRAIN: tx_valid=0; fifo_rd_en = !fifo_empty; pop through EOF word inclusive, then WAIT_DONE.
REQ-032 WAIT_DONE: on tx_done, pulse sts_done, set sts_err=01 if tx_ok=0 (keep 11 if already set), else keep current; ->IDLE.
REQ-033 FLUSH: fifo_rd_en = !fifo_empty until EOF word popped, then pulse sts_done, ->IDLE; tx_valid=0.
REQ-034 sts_err SHALL clear to 00 on IDLE->REQ.
REQ-035 tx_gnt outside REQ and tx_done outside WAIT_DONE SHALL be ignored.
REQ-036 tx_done arriving same cycle as EOF acceptance SHALL be ignored; only WAIT_DONE samples it.
REQ-037 fifo_rd_en SHALL never assert while fifo_empty=1.

Reset
REQ-038 rst SHALL force state IDLE, counters 0, frame_len=0, sts_err=00, all outputs 0, effective next rd_clk edge.
REQ-039 rst mid-frame SHALL abandon the frame without draining; FIFO recovery is the owner's job.

Verification
REQ-040 3-dword frame (A,B,C; C EOF), tx_gnt after 2 cycles, tx_ready=1 -> sof on A, eof on C, 3 pops, frame_len=3, sts_done after tx_done(ok=1), sts_err=00.
REQ-041 Same frame with tx_ready low 4 cycles on B -> B held stable, no pop while low, frame_len=3.
REQ-042 fifo_empty 5 cycles between A and B -> tx_valid=0 those cycles, frame completes, sts_err=00.
REQ-043 No tx_gnt for C_GNT_TIMEOUT cycles -> FLUSH pops whole frame, sts_err=10, sts_done pulse, tx_valid never 1.
REQ-044 2060-dword frame without early EOF -> tx_eof on dword 2049, 11 further pops, sts_err=11 after tx_done(ok=1).
REQ-045 rst asserted mid-XFER after 2 dwords -> next cycle busy=0, tx_valid=0, frame_len=0, sts_err=00.
